// File: rtl/rotary_speed_ctrl.sv
// rotary_speed_ctrl: synchronizes and debounces a quadrature encoder and a button, then drives a registered speed level and spin direction
module rotary_speed_ctrl #(
  parameter int unsigned DEBOUNCE_WIDTH = 16,
  parameter int unsigned SPEED_RESET    = 3,
  parameter int unsigned DIR_RESET      = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       btn,
  output logic [2:0] speed_n,
  output logic       direction,
  output logic       speed_changed,
  output logic       enc_error
);
  logic [2:0] sync1_q, sync2_q, deb;
  logic [1:0] prev_q, cur;
  logic [2:0] speed_n_q, speed_n_d, level;
  logic       btn_prev_q, dir_q, chg_q, err_q;
  logic       cw, ccw, ill, inc, dec;
  for (genvar i = 0; i < 3; i++) begin : g_deb
    logic [DEBOUNCE_WIDTH-1:0] cnt_q;
    logic                      d_q;
    always_ff @(posedge clk)
      if (reset) begin
        cnt_q <= '0;
        d_q   <= 1'b0;
      end else if (sync2_q[i] == d_q) cnt_q <= '0;
      else if (&cnt_q) begin
        d_q   <= sync2_q[i];
        cnt_q <= '0;
      end else cnt_q <= cnt_q + 1'b1;
    assign deb[i] = d_q;
  end
  assign cur   = deb[2:1];
  assign level = ~speed_n_q;
  // only the two detent transitions into 00 move the level; a two-bit jump is an error
  assign cw    = (prev_q == 2'b10) && (cur == 2'b00);
  assign ccw   = (prev_q == 2'b01) && (cur == 2'b00);
  assign ill   = (prev_q ^ cur) == 2'b11;
  assign inc   = cw && (level != 3'd7);
  assign dec   = ccw && (level != 3'd0);
  always_comb speed_n_d = ~(inc ? level + 3'd1 : dec ? level - 3'd1 : level);
  always_ff @(posedge clk)
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      btn_prev_q <= 1'b0;
      speed_n_q  <= ~3'(SPEED_RESET);
      dir_q      <= 1'(DIR_RESET);
      chg_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= {enc_a, enc_b, btn};
      sync2_q    <= sync1_q;
      prev_q     <= cur;
      btn_prev_q <= deb[0];
      speed_n_q  <= speed_n_d;
      dir_q      <= dir_q ^ (deb[0] & ~btn_prev_q);
      chg_q      <= inc | dec;
      err_q      <= ill;
    end
  assign speed_n       = speed_n_q;
  assign direction     = dir_q;
  assign speed_changed = chg_q;
  assign enc_error     = err_q;
endmodule

// File: tb/tb_rotary_speed_ctrl.sv
// tb_rotary_speed_ctrl: scoreboard bench; an encoder/button model queues expected events, a negedge monitor pops and checks them
module tb_rotary_speed_ctrl;
  logic       clk = 1'b0, reset = 1'b1, enc_a = 1'b0, enc_b = 1'b0, btn = 1'b0;
  logic [2:0] speed_n;
  logic       direction, speed_changed, enc_error;
  int         n_checks = 0, n_fails = 0;
  logic [4:0] exp_q[$];
  int         m_level = 3;
  logic       m_dir = 1'b1, last_dir = 1'b1;
  logic [1:0] m_prev = 2'b00;
  rotary_speed_ctrl #(.DEBOUNCE_WIDTH(4), .SPEED_RESET(3), .DIR_RESET(1)) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .btn(btn),
    .speed_n(speed_n), .direction(direction),
    .speed_changed(speed_changed), .enc_error(enc_error)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // event code {kind, value}: kind 0 speed change (value speed_n), 1 enc_error, 2 direction
  task automatic pop_event(input logic [4:0] obs);
    if (exp_q.size() == 0) check("unexpected_event", {3'd0, obs}, 8'hff);
    else check("event", {3'd0, obs}, {3'd0, exp_q.pop_front()});
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (speed_changed) pop_event({2'd0, speed_n});
      if (enc_error) pop_event({2'd1, 3'd0});
      if (direction != last_dir) pop_event({2'd2, 2'd0, direction});
    end
    last_dir = direction;
  end
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic model_enc(input logic [1:0] ab);
    if ((ab ^ m_prev) == 2'b11) exp_q.push_back({2'd1, 3'd0});
    else if (ab == 2'b00 && m_prev == 2'b10 && m_level < 7) begin
      m_level++;
      exp_q.push_back({2'd0, ~3'(m_level)});
    end else if (ab == 2'b00 && m_prev == 2'b01 && m_level > 0) begin
      m_level--;
      exp_q.push_back({2'd0, ~3'(m_level)});
    end
    m_prev = ab;
  endtask
  task automatic toggle_dir();
    m_dir = ~m_dir;
    exp_q.push_back({2'd2, 2'd0, m_dir});
  endtask
  task automatic step(input logic [1:0] ab);
    model_enc(ab);
    {enc_a, enc_b} = ab;
    wait_cyc(40);
  endtask
  task automatic cw();
    step(2'b01); step(2'b11); step(2'b10); step(2'b00);
  endtask
  task automatic ccw();
    step(2'b10); step(2'b11); step(2'b01); step(2'b00);
  endtask
  task automatic press();
    toggle_dir();
    btn = 1'b1;
    wait_cyc(40);
    btn = 1'b0;
    wait_cyc(40);
  endtask
  initial begin
    wait_cyc(3);
    check("rst_speed_n", {5'd0, speed_n}, 8'h04);
    check("rst_dir", {7'd0, direction}, 8'h01);
    check("rst_chg", {7'd0, speed_changed}, 8'h00);
    check("rst_err", {7'd0, enc_error}, 8'h00);
    reset = 1'b0;
    enc_a = 1'b1;
    wait_cyc(10);
    enc_a = 1'b0;
    wait_cyc(40);
    check("glitch_speed_n", {5'd0, speed_n}, 8'h04);
    check("glitch_pending", 8'(exp_q.size()), 8'h00);
    cw();
    check("cw1_speed_n", {5'd0, speed_n}, 8'h03);
    repeat (5) cw();
    check("cw_sat_speed_n", {5'd0, speed_n}, 8'h00);
    repeat (6) ccw();
    check("ccw_lvl1_speed_n", {5'd0, speed_n}, 8'h06);
    repeat (2) ccw();
    check("ccw_sat_speed_n", {5'd0, speed_n}, 8'h07);
    check("ccw_pending", 8'(exp_q.size()), 8'h00);
    step(2'b11);
    check("illegal_speed_n", {5'd0, speed_n}, 8'h07);
    step(2'b00);
    check("illegal2_speed_n", {5'd0, speed_n}, 8'h07);
    press();
    check("btn1_dir", {7'd0, direction}, 8'h00);
    press();
    check("btn2_dir", {7'd0, direction}, 8'h01);
    step(2'b01); step(2'b11); step(2'b10);
    model_enc(2'b00);
    toggle_dir();
    {enc_a, enc_b} = 2'b00;
    btn = 1'b1;
    wait_cyc(40);
    btn = 1'b0;
    wait_cyc(40);
    check("simul_speed_n", {5'd0, speed_n}, 8'h06);
    check("simul_dir", {7'd0, direction}, 8'h00);
    check("simul_pending", 8'(exp_q.size()), 8'h00);
    btn = 1'b1;
    wait_cyc(10);
    reset = 1'b1;
    m_level = 3;
    m_dir = 1'b1;
    m_prev = 2'b00;
    wait_cyc(3);
    check("midrst_dir", {7'd0, direction}, 8'h01);
    check("midrst_speed_n", {5'd0, speed_n}, 8'h04);
    reset = 1'b0;
    wait_cyc(5);
    btn = 1'b0;
    wait_cyc(40);
    check("postrst_dir", {7'd0, direction}, 8'h01);
    check("final_pending", 8'(exp_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end
endmodule
